// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between fetch_unit (master) and instruction memory (slave).
// One request is held until a single-cycle ready returns the read data.
interface fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (output mem_req, mem_addr, input mem_rdata, mem_ready);
   modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/fetch_unit.sv
// Responder to fetch/decode/execute phase strobes: reads the IR, splits its fields and retires it.
// Optional macro FETCH_PHASE_CHECK_EN builds a sticky phase-order error flag (phase_err).
module fetch_unit #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              fetch,
   input  logic              decode,
   input  logic              execute,
   fetch_unit_if.master      mem,
   input  logic              br_take,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        opcode,
   output logic [3:0]        rd,
   output logic [3:0]        rs,
   output logic [7:0]        imm8,
   output logic              ir_valid,
   output logic              dec_valid,
   output logic              stall,
   output logic              exec_done,
   output logic              phase_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      HAVE_IR = 2'd2,
      DECODED = 2'd3
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [DATA_W-1:0] ir_r;
   logic [3:0]        opcode_r, rd_r, rs_r;
   logic [7:0]        imm8_r;
   logic              mem_req_r, stall_r, ir_valid_r, dec_valid_r, exec_done_r;
   logic              fetch_d_r, decode_d_r, execute_d_r;
   logic              fetch_e_s, decode_e_s, execute_e_s;

   assign fetch_e_s   = fetch   & ~fetch_d_r;
   assign decode_e_s  = decode  & ~decode_d_r;
   assign execute_e_s = execute & ~execute_d_r;

   // Phase FSM; a read in BUSY completes even with en low so memory never hangs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         ir_r        <= {DATA_W{1'b0}};
         opcode_r    <= 4'd0;
         rd_r        <= 4'd0;
         rs_r        <= 4'd0;
         imm8_r      <= 8'd0;
         mem_req_r   <= 1'b0;
         stall_r     <= 1'b0;
         ir_valid_r  <= 1'b0;
         dec_valid_r <= 1'b0;
         exec_done_r <= 1'b0;
         fetch_d_r   <= 1'b0;
         decode_d_r  <= 1'b0;
         execute_d_r <= 1'b0;
      end else begin
         fetch_d_r   <= fetch;
         decode_d_r  <= decode;
         execute_d_r <= execute;
         exec_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (en && fetch_e_s) begin
                  mem_req_r <= 1'b1;
                  stall_r   <= 1'b1;
                  state_r   <= BUSY;
               end
            end
            BUSY: begin
               if (mem.mem_ready) begin
                  ir_r       <= mem.mem_rdata;
                  pc_r       <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  mem_req_r  <= 1'b0;
                  stall_r    <= 1'b0;
                  ir_valid_r <= 1'b1;
                  state_r    <= HAVE_IR;
               end
            end
            HAVE_IR: begin
               if (en && decode_e_s) begin
                  opcode_r    <= ir_r[15:12];
                  rd_r        <= ir_r[11:8];
                  rs_r        <= ir_r[7:4];
                  imm8_r      <= ir_r[7:0];
                  dec_valid_r <= 1'b1;
                  state_r     <= DECODED;
               end
            end
            DECODED: begin
               if (en && execute_e_s) begin
                  pc_r        <= br_take ? br_target : pc_r;
                  ir_valid_r  <= 1'b0;
                  dec_valid_r <= 1'b0;
                  exec_done_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PHASE_CHECK_EN
   logic phase_err_r;
   logic order_err_s, multi_s;

   // Ignored edges and overlapping strobes are flagged only while enabled.
   always_comb begin
      order_err_s = en & ((fetch_e_s   & (state_r != IDLE))    |
                          (decode_e_s  & (state_r != HAVE_IR)) |
                          (execute_e_s & (state_r != DECODED)));
      multi_s     = en & ((fetch & decode) | (fetch & execute) | (decode & execute));
   end

   // Sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_err_r <= 1'b0;
      end else begin
         phase_err_r <= phase_err_r | order_err_s | multi_s;
      end
   end

   assign phase_err = phase_err_r;
`else
   assign phase_err = 1'b0;
`endif

   assign mem.mem_req  = mem_req_r;
   assign mem.mem_addr = pc_r;
   assign pc           = pc_r;
   assign ir           = ir_r;
   assign opcode       = opcode_r;
   assign rd           = rd_r;
   assign rs           = rs_r;
   assign imm8         = imm8_r;
   assign ir_valid     = ir_valid_r;
   assign dec_valid    = dec_valid_r;
   assign stall        = stall_r;
   assign exec_done    = exec_done_r;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Responder side of the fetch/decode/execute phase strobes produced by the CPU phase sequencer. It performs the work each phase requests.
- On fetch: issues a memory read at the PC and loads the IR. On decode: splits the IR into fields. On execute: applies the branch/PC update and retires the instruction.
- Sits between the phase sequencer, instruction memory and the datapath. It back-pressures the sequencer with stall while memory is slow.

Parameters:
- DATA_W, 16, instruction and memory data width.
- ADDR_W, 16, PC and memory address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  global enable; low freezes phase handling (see Behaviour).
- fetch  in  1  fetch phase strobe from sequencer.
- decode  in  1  decode phase strobe from sequencer.
- execute  in  1  execute phase strobe from sequencer.
- mem_req  out  1  instruction read request, held until mem_ready.
- mem_addr  out  ADDR_W  read address (equals pc while mem_req).
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- mem_ready  in  1  read completion, one cycle.
- br_take  in  1  branch taken, sampled on execute edge.
- br_target  in  ADDR_W  branch target, sampled on execute edge.
- pc  out  ADDR_W  program counter.
- ir  out  DATA_W  instruction register.
- opcode  out  4  ir[15:12], registered on decode.
- rd  out  4  ir[11:8], registered on decode.
- rs  out  4  ir[7:4], registered on decode.
- imm8  out  8  ir[7:0], registered on decode.
- ir_valid  out  1  IR holds a fetched, unretired instruction.
- dec_valid  out  1  decoded fields valid.
- stall  out  1  fetch in progress; sequencer must hold.
- exec_done  out  1  one-cycle pulse on retire.
- phase_err  out  1  sticky phase-order error (optional feature).

Behaviour:
- Reset values:
  - pc=RESET_PC; ir, opcode, rd, rs, imm8 = 0.
  - mem_req, ir_valid, dec_valid, stall, exec_done, phase_err = 0.
  - State=IDLE; strobe history registers = 0.
- Strobe handling: strobes are levels. Each phase acts only on its rising edge (strobe & ~strobe_d); strobe_d is registered every cycle regardless of en.
- State machine: IDLE, BUSY, HAVE_IR, DECODED.
- IDLE: on en & fetch edge, set mem_req=1, mem_addr=pc, stall=1, go to BUSY.
- BUSY: on mem_ready:
  - ir<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W).
  - mem_req<=0, stall<=0, ir_valid<=1, go to HAVE_IR.
  - mem_ready is accepted even when en=0, so a transaction never hangs.
  - Minimum latency: fetch edge sampled at cycle N gives ir_valid at N+2 (mem_ready high at N+1).
- HAVE_IR: on en & decode edge, register opcode/rd/rs/imm8 from ir, dec_valid<=1, go to DECODED.
- DECODED: on en & execute edge:
  - pc<=br_take ? br_target : pc.
  - ir_valid<=0, dec_valid<=0.
  - exec_done=1 for exactly one cycle; go to IDLE.
- en=0: no phase edge acts; all outputs hold, except completion of an outstanding BUSY read.
- Out-of-order strobes are ignored and cause no state change:
  - fetch edge outside IDLE;
  - decode edge outside HAVE_IR;
  - execute edge outside DECODED.
- Multiple strobes high in one cycle: only the edge legal for the current state acts.
- mem_ready outside BUSY is ignored.
- Reset mid-fetch: mem_req and stall drop asynchronously. A late mem_ready is ignored, and the next fetch re-reads from RESET_PC.

Optional Feature:
- Macro: FETCH_PHASE_CHECK_EN.
- Defined: phase_err is set (sticky until reset) on any ignored out-of-order edge, or when more than one of fetch/decode/execute is high in the same cycle while en=1.
- Not defined: phase_err is tied to 0 and no checking logic is built. Functional behaviour is otherwise identical.

Test Plan:
- Reset release, pulse fetch, mem_ready after 3 cycles with mem_rdata=16'h1A2B -> mem_addr=0 while mem_req; ir=1A2B, pc=1, stall high for exactly 3 cycles.
- Fetch, then decode, then execute with br_take=0, ir=16'h1A2B -> opcode=1, rd=A, rs=2, imm8=2B; exec_done pulses once; pc stays 1; ir_valid=0.
- Execute with br_take=1, br_target=16'h00F0 -> pc=00F0; next fetch gives mem_addr=00F0.
- pc=16'hFFFF, fetch and complete -> pc wraps to 0.
- Assert reset during BUSY, then raise mem_ready -> mem_req=0 immediately, ir stays 0, state IDLE, next fetch mem_addr=RESET_PC.
- With FETCH_PHASE_CHECK_EN defined, decode edge in IDLE -> no state change, phase_err=1 and stays 1 until reset. Without the macro -> phase_err=0.
